// File: rtl/lane_arbiter.sv
// Round-robin merge of two first-word-fall-through lane FIFOs into one byte stream.
// Each lane gets up to MAX_BURST consecutive pops before the path is handed over.
module lane_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              empty_0,
  input  logic              empty_1,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic              pause,
  output logic              pop_0,
  output logic              pop_1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              active_lane,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  state_t            state, state_nxt, oth_state;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              last_lane;
  logic              cur_lane, cur_empty, oth_empty, pop_any;
  logic [DATA_W-1:0] cur_data;

  assign cur_lane  = (state == SERVE1);
  assign cur_empty = cur_lane ? empty_1 : empty_0;
  assign oth_empty = cur_lane ? empty_0 : empty_1;
  assign cur_data  = cur_lane ? data_in_1 : data_in_0;
  assign oth_state = cur_lane ? SERVE0 : SERVE1;

  assign pop_0   = reset_L & (state == SERVE0) & ~empty_0 & ~pause;
  assign pop_1   = reset_L & (state == SERVE1) & ~empty_1 & ~pause;
  assign pop_any = pop_0 | pop_1;

  // SERVE0/SERVE1 share one branch; the lane being served is selected by cur_lane.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!pause) begin
          if (!empty_0 && !empty_1) state_nxt = last_lane ? SERVE0 : SERVE1;
          else if (!empty_0)        state_nxt = SERVE0;
          else if (!empty_1)        state_nxt = SERVE1;
        end
      end
      SERVE0, SERVE1: begin
        if (!pause) begin
          if (cur_empty) begin
            cnt_nxt   = '0;
            state_nxt = oth_empty ? IDLE : oth_state;
          end else if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (!oth_empty) state_nxt = oth_state;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      cnt         <= '0;
      last_lane   <= 1'b1;
      data_out    <= '0;
      valid_out   <= 1'b0;
      active_lane <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      busy        <= (state_nxt != IDLE);
      active_lane <= (state_nxt == SERVE1);
      valid_out   <= pop_any;
      if (pop_any) begin
        data_out  <= cur_data;
        last_lane <= cur_lane;
      end
    end
  end

endmodule

// File: tb/tb_lane_arbiter.sv
// Bench for lane_arbiter: two instances (MAX_BURST=4 and 1) fed by modelled FWFT FIFOs,
// compared cycle by cycle against a burst/turn-taking reference model.
module tb_lane_arbiter;

  logic clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  logic reset_L, pause;

  // FIFO contents per instance [k] and lane [l]
  logic [7:0] fmem [2][2][256];
  logic [7:0] wp [2][2];
  logic [7:0] rp [2][2];

  logic       e0_a, e1_a, e0_b, e1_b;
  logic [7:0] d0_a, d1_a, d0_b, d1_b;
  logic       pop0_a, pop1_a, pop0_b, pop1_b;
  logic [7:0] dout_a, dout_b;
  logic       vout_a, vout_b, alane_a, alane_b, busy_a, busy_b;

  assign e0_a = (wp[0][0] == rp[0][0]);
  assign e1_a = (wp[0][1] == rp[0][1]);
  assign e0_b = (wp[1][0] == rp[1][0]);
  assign e1_b = (wp[1][1] == rp[1][1]);
  assign d0_a = fmem[0][0][rp[0][0]];
  assign d1_a = fmem[0][1][rp[0][1]];
  assign d0_b = fmem[1][0][rp[1][0]];
  assign d1_b = fmem[1][1][rp[1][1]];

  lane_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut_a (
    .clk_2f(clk_2f), .reset_L(reset_L), .empty_0(e0_a), .empty_1(e1_a),
    .data_in_0(d0_a), .data_in_1(d1_a), .pause(pause),
    .pop_0(pop0_a), .pop_1(pop1_a), .data_out(dout_a), .valid_out(vout_a),
    .active_lane(alane_a), .busy(busy_a)
  );

  lane_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut_b (
    .clk_2f(clk_2f), .reset_L(reset_L), .empty_0(e0_b), .empty_1(e1_b),
    .data_in_0(d0_b), .data_in_1(d1_b), .pause(pause),
    .pop_0(pop0_b), .pop_1(pop1_b), .data_out(dout_b), .valid_out(vout_b),
    .active_lane(alane_b), .busy(busy_b)
  );

  logic [1:0] pops [2];
  logic [7:0] dout [2];
  logic       vout [2], alane [2], busyv [2];
  assign pops[0] = {pop1_a, pop0_a};
  assign pops[1] = {pop1_b, pop0_b};
  assign dout[0] = dout_a;  assign dout[1] = dout_b;
  assign vout[0] = vout_a;  assign vout[1] = vout_b;
  assign alane[0] = alane_a; assign alane[1] = alane_b;
  assign busyv[0] = busy_a; assign busyv[1] = busy_b;

  // Reference model: is a lane being served, which one, words used in this burst
  int         srv [2], ln [2], used [2], last [2];
  logic [7:0] m_data [2];
  logic       m_valid [2];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  function automatic int burst_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int k, input int l, input logic [7:0] v);
    fmem[k][l][wp[k][l]] = v;
    wp[k][l] = wp[k][l] + 8'd1;
  endtask

  function automatic logic [7:0] fill(input int k, input int l);
    return wp[k][l] - rp[k][l];
  endfunction

  task automatic model_reset(input int k);
    srv[k] = 0; ln[k] = 0; used[k] = 0; last[k] = 1;
    m_valid[k] = 1'b0; m_data[k] = 8'h00;
  endtask

  function automatic logic [1:0] model_pop(input int k, input bit rst, input bit p,
                                           input bit e0, input bit e1);
    bit e_cur;
    e_cur = (ln[k] == 1) ? e1 : e0;
    if (rst && srv[k] != 0 && !p && !e_cur) return (ln[k] == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic model_step(input int k, input bit rst, input bit p, input bit e0, input bit e1,
                            input logic [7:0] h0, input logic [7:0] h1);
    bit e [2];
    int popl;
    if (!rst) begin
      model_reset(k);
      return;
    end
    e[0] = e0; e[1] = e1;
    popl = -1;
    if (srv[k] != 0 && !p && !e[ln[k]]) popl = ln[k];
    if (srv[k] == 0) begin
      if (!p && (!e0 || !e1)) begin
        srv[k] = 1; used[k] = 0;
        if (!e0 && !e1) ln[k] = 1 - last[k];
        else            ln[k] = e0 ? 1 : 0;
      end
    end else if (!p) begin
      if (e[ln[k]]) begin
        used[k] = 0;
        if (!e[1 - ln[k]]) ln[k] = 1 - ln[k];
        else               srv[k] = 0;
      end else begin
        used[k]++;
        if (used[k] == burst_of(k)) begin
          used[k] = 0;
          if (!e[1 - ln[k]]) ln[k] = 1 - ln[k];
        end
      end
    end
    if (popl >= 0) begin
      last[k] = popl; m_data[k] = (popl == 1) ? h1 : h0; m_valid[k] = 1'b1;
    end else begin
      m_valid[k] = 1'b0;
    end
  endtask

  task automatic check_outputs(input int k);
    string sfx;
    sfx = (k == 0) ? "_a" : "_b";
    check_eq({"valid", sfx}, 32'(vout[k]), 32'(m_valid[k]));
    check_eq({"data", sfx}, 32'(dout[k]), 32'(m_data[k]));
    check_eq({"busy", sfx}, 32'(busyv[k]), 32'(srv[k] != 0));
    check_eq({"lane", sfx}, 32'(alane[k]), 32'(srv[k] != 0 && ln[k] == 1));
  endtask

  // One clock: inputs already driven; check pops, advance model and FIFOs, check outputs.
  task automatic cycle();
    bit         s_rst, s_p;
    bit         s_e [2][2];
    logic [7:0] s_h [2][2];
    logic [1:0] ep [2];
    #2;
    s_rst = reset_L; s_p = pause;
    for (int k = 0; k < 2; k++) begin
      for (int l = 0; l < 2; l++) begin
        s_e[k][l] = (wp[k][l] == rp[k][l]);
        s_h[k][l] = fmem[k][l][rp[k][l]];
      end
      ep[k] = model_pop(k, s_rst, s_p, s_e[k][0], s_e[k][1]);
      check_eq((k == 0) ? "pop_a" : "pop_b", 32'(pops[k]), 32'(ep[k]));
    end
    @(posedge clk_2f);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      model_step(k, s_rst, s_p, s_e[k][0], s_e[k][1], s_h[k][0], s_h[k][1]);
      if (ep[k][0]) rp[k][0] = rp[k][0] + 8'd1;
      if (ep[k][1]) rp[k][1] = rp[k][1] + 8'd1;
      check_outputs(k);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_both(input int na, input int nb, input logic [7:0] base);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < na; i++) push(k, 0, 8'hA0 + base + 8'(i));
      for (int i = 0; i < nb; i++) push(k, 1, 8'hB0 + base + 8'(i));
    end
  endtask

  initial begin
    reset_L = 1'b0;
    pause   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      for (int l = 0; l < 2; l++) begin wp[k][l] = 8'd0; rp[k][l] = 8'd0; end
    end

    // Reset with both FIFOs holding data, then full drain (alternation / 4-word bursts)
    load_both(8, 8, 8'h00);
    run(2);
    check_eq("rst_pop_a", 32'(pops[0]), 32'd0);
    check_eq("rst_data_a", 32'(dout_a), 32'd0);
    reset_L = 1'b1;
    run(22);

    // Lane 1 alone, longer than one burst
    for (int k = 0; k < 2; k++) for (int i = 0; i < 6; i++) push(k, 1, 8'hC0 + 8'(i));
    run(10);

    // Lane 0 runs dry mid-burst while lane 1 waits
    load_both(2, 4, 8'h08);
    run(10);

    // Pause after two words of a lane-0 burst
    load_both(6, 4, 8'h10);
    run(3);
    pause = 1'b1;
    run(3);
    pause = 1'b0;
    run(16);

    // Asynchronous reset in the middle of a burst
    load_both(5, 5, 8'h20);
    run(3);
    reset_L = 1'b0;
    #1;
    check_eq("arst_pop_a", 32'(pops[0]), 32'd0);
    check_eq("arst_pop_b", 32'(pops[1]), 32'd0);
    check_eq("arst_valid_a", 32'(vout_a), 32'd0);
    check_eq("arst_data_a", 32'(dout_a), 32'd0);
    check_eq("arst_busy_b", 32'(busy_b), 32'd0);
    model_reset(0);
    model_reset(1);
    run(1);
    reset_L = 1'b1;
    run(25);

    // Randomized traffic and backpressure
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++)
        for (int l = 0; l < 2; l++)
          if ($urandom_range(0, 99) < 40 && fill(k, l) < 8'd200) push(k, l, 8'($urandom));
      pause = ($urandom_range(0, 99) < 15);
      cycle();
    end
    pause = 1'b0;
    run(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_arbiter.md
# lane_arbiter

Round-robin arbiter that merges two 8-bit lane FIFOs into one byte stream on the clk_2f domain. It is the transmit-side counterpart of the lane demultiplexer. It pops head-of-queue words from lane 0 and lane 1 FIFOs, which are first-word-fall-through. It grants each lane up to MAX_BURST consecutive words, then hands the shared byte path to the other lane. It respects downstream backpressure and drives a registered data/valid pair toward the byte-stripe datapath.

## Interface
Parameters:
- DATA_W, 8: word width of both lanes and the output.
- MAX_BURST, 4: maximum consecutive pops granted to one lane while the other lane has data. Legal range is 1..16. A value of 1 gives strict alternation.

Ports:
- clk_2f  in  1  byte clock; all state updates on its rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- empty_0  in  1  lane 0 FIFO empty flag.
- empty_1  in  1  lane 1 FIFO empty flag.
- data_in_0  in  DATA_W  lane 0 FIFO head word; meaningful while empty_0=0.
- data_in_1  in  DATA_W  lane 1 FIFO head word; meaningful while empty_1=0.
- pause  in  1  downstream backpressure; no pops while high.
- pop_0  out  1  combinational pop strobe to lane 0 FIFO.
- pop_1  out  1  combinational pop strobe to lane 1 FIFO.
- data_out  out  DATA_W  registered merged word.
- valid_out  out  1  registered; high for one cycle per popped word.
- active_lane  out  1  registered; 1 in SERVE1, else 0.
- busy  out  1  registered; high in SERVE0 or SERVE1.

## Operation
- FSM states are IDLE, SERVE0 and SERVE1.
- Internal registers:
  - burst counter cnt, width $clog2(MAX_BURST)+1, reset value 0.
  - last_lane, reset value 1, so lane 0 is served first after reset.
- Reset values: state=IDLE, cnt=0, last_lane=1, data_out=0, valid_out=0, active_lane=0, busy=0. pop_0 and pop_1 are forced to 0 while reset_L=0.
- Pop rule (combinational): pop_n = reset_L & (state==SERVEn) & ~empty_n & ~pause. A pop never occurs in IDLE.
- IDLE:
  - If pause=1, stay in IDLE.
  - If both lanes are empty, stay in IDLE.
  - If exactly one lane is non-empty, go to that lane's SERVE state.
  - If both are non-empty, go to SERVE of ~last_lane.
  - cnt=0 on every exit from IDLE.
- SERVEn (the other lane is m):
  - pause=1: hold state and cnt; no pop.
  - pause=0 and empty_n=1: no pop; cnt<=0. Go to SERVEm if empty_m=0, else go to IDLE.
  - pause=0, empty_n=0, cnt<MAX_BURST-1: pop; cnt<=cnt+1; stay in SERVEn.
  - pause=0, empty_n=0, cnt==MAX_BURST-1: pop; cnt<=0. Go to SERVEm if empty_m=0, else stay in SERVEn and start a fresh burst.
- On every pop of lane n: last_lane<=n, data_out<=data_in_n, valid_out<=1.
- Cycles without a pop: valid_out<=0 and data_out holds its last value.
- pop_0 and pop_1 are never high in the same cycle.

## Timing
- Pop in cycle k puts data_out and valid_out on the rising edge that ends cycle k. Latency is one clock from the pop strobe.
- Burst-limit handoff has no bubble. The last pop of the lane n burst is in cycle k, and the first pop of lane m is in cycle k+1.
- Empty-detected handoff costs exactly one bubble cycle (valid_out=0), spent in the SERVEn cycle that sees empty_n=1.
- Leaving IDLE takes one cycle with no pop. The first valid_out is 2 cycles after a lane first shows non-empty with pause=0.
- pause affects pop in the same cycle combinationally. valid_out drops on the next edge. Serving resumes in the state and at the cnt held during pause.
- Asynchronous reset mid-burst:
  - All registers return to their reset values immediately, and pops deassert immediately.
  - After release, the first grant goes to lane 0 if it is non-empty.
- Simultaneous pause=1 with burst expiry: pause wins; nothing advances.

## Test plan
- Reset: assert reset_L=0 with both FIFOs non-empty -> pop_0=pop_1=0, valid_out=0, data_out=0, busy=0. Release -> IDLE, then SERVE0, and the first data_out is lane 0's head word.
- MAX_BURST=1, lane0 holds A0..A3, lane1 holds B0..B3, pause=0 -> data_out sequence is A0,B0,A1,B1,A2,B2,A3,B3 with valid_out continuously high for 8 cycles.
- MAX_BURST=4, both lanes hold 8 words -> A0..A3, B0..B3, A4..A7, B4..B7 with no bubbles. Then one bubble cycle, then IDLE with busy=0.
- Only lane1 holds 6 words, MAX_BURST=4 -> B0..B5 contiguous. cnt wraps after B3 and the arbiter stays in SERVE1. pop_0 never asserts.
- pause=1 for 3 cycles after the 2nd word of a lane 0 burst -> no pops during pause, and valid_out=0 for the 3 cycles after pause rises. The burst then resumes with exactly 2 more lane 0 words before the handoff.
- Lane0 empties after 2 of 4 words while lane1 is non-empty -> A0, A1, one bubble, then B0 from SERVE1.
